ray_angle_generator: RTL and testbench

//  Per-frame ray sweep stage, directly downstream of the player/angle input controller.
//  On frame_start it snapshots player position and view angle (integer degrees + thousandths).
//  It then emits one ray angle per screen column across the field of view, leftmost column first.

---
 rtl/raycast_pkg.sv | 61 ++++++
 rtl/angle_mod_addsub.sv | 31 +++
 rtl/ray_angle_generator.sv | 141 ++++++++++++++
 tb/tb_ray_angle_generator.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/raycast_pkg.sv
// Shared constants and helpers for the raycaster angle/pose datapath.
// Angles are carried internally as unsigned 1/8-degree counts (a8).
package raycast_pkg;

    localparam int ANGLE_W = 10;
    localparam int POS_W   = 13;
    localparam int A8_W    = 12;
    localparam int COL_W   = 8;

    // One full turn in 1/8-degree units, and thousandths per eighth.
    localparam logic [A8_W-1:0]    ANGLE_FULL_EIGHTHS = 12'd2880;
    localparam logic [ANGLE_W-1:0] FRAC_STEP          = 10'd125;

    // Pose presented while idle after reset: (96, 96) facing 90.000 deg.
    localparam logic [POS_W-1:0]   RESET_POS     = 13'd96;
    localparam logic [ANGLE_W-1:0] RESET_ANGLE_X = 10'd90;
    localparam logic [ANGLE_W-1:0] RESET_ANGLE_Y = 10'd0;
    localparam logic [A8_W-1:0]    RESET_A8      = 12'd720;

    // Sweep FSM encoding.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_EMIT = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // Thousandths {0,125,..,875} -> eighths 0..7 by threshold compare.
    function automatic logic [2:0] frac_to_eighths(
        input logic [ANGLE_W-1:0] frac
    );
        logic [2:0] e;
        if (frac >= FRAC_STEP * 10'd7)      e = 3'd7;
        else if (frac >= FRAC_STEP * 10'd6) e = 3'd6;
        else if (frac >= FRAC_STEP * 10'd5) e = 3'd5;
        else if (frac >= FRAC_STEP * 10'd4) e = 3'd4;
        else if (frac >= FRAC_STEP * 10'd3) e = 3'd3;
        else if (frac >= FRAC_STEP * 10'd2) e = 3'd2;
        else if (frac >= FRAC_STEP)         e = 3'd1;
        else                                e = 3'd0;
        return e;
    endfunction

    // Eighths 0..7 -> thousandths 0..875.
    function automatic logic [ANGLE_W-1:0] eighths_to_frac(
        input logic [2:0] e
    );
        logic [ANGLE_W-1:0] f;
        unique case (e)
            3'd0: f = 10'd0;
            3'd1: f = 10'd125;
            3'd2: f = 10'd250;
            3'd3: f = 10'd375;
            3'd4: f = 10'd500;
            3'd5: f = 10'd625;
            3'd6: f = 10'd750;
            3'd7: f = 10'd875;
            default: f = 10'd0;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/angle_mod_addsub.sv
// Combinational a +/- b on 1/8-degree angles, wrapped into 0..2879.
// Both operands are assumed already inside one turn.
module angle_mod_addsub
    import raycast_pkg::*;
(
    input  logic [A8_W-1:0] a,
    input  logic [A8_W-1:0] b,
    input  logic            sub,
    output logic [A8_W-1:0] y
);

    logic [A8_W:0] sum;
    logic [A8_W:0] diff;
    logic [A8_W:0] full;

    // Single conditional correction is enough since |a op b| < 2 turns.
    always_comb begin
        full = {1'b0, ANGLE_FULL_EIGHTHS};
        sum  = {1'b0, a} + {1'b0, b};
        diff = {1'b0, a} - {1'b0, b};
        y    = a;
        if (sub) begin
            if (diff[A8_W]) y = 12'(diff + full);
            else            y = diff[A8_W-1:0];
        end else begin
            if (sum >= full) y = 12'(sum - full);
            else             y = sum[A8_W-1:0];
        end
    end

endmodule

// File: rtl/ray_angle_generator.sv
// Per-frame ray sweep: snapshots pose on frame_start, then emits one
// ray angle per column, leftmost first, over a valid/ready handshake.
module ray_angle_generator
    import raycast_pkg::*;
#(
    parameter int NUM_COLUMNS  = 160,
    parameter int FOV_EIGHTHS  = 480,
    parameter int STEP_EIGHTHS = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        frame_start,
    input  logic [12:0] playerX,
    input  logic [12:0] playerY,
    input  logic [9:0]  angle_X,
    input  logic [9:0]  angle_Y,
    input  logic        ray_ready,
    output logic        ray_valid,
    output logic [7:0]  ray_column,
    output logic [9:0]  ray_angle_X,
    output logic [9:0]  ray_angle_Y,
    output logic [12:0] ray_playerX,
    output logic [12:0] ray_playerY,
    output logic        busy,
    output logic        frame_done
);

    localparam logic [A8_W-1:0]  HALF_FOV = 12'(FOV_EIGHTHS / 2);
    localparam logic [A8_W-1:0]  STEP     = 12'(STEP_EIGHTHS);
    localparam logic [COL_W-1:0] LAST_COL = 8'(NUM_COLUMNS - 1);

    logic [1:0]       state_q,  state_d;
    logic [A8_W-1:0]  a8_q,     a8_d;
    logic [A8_W-1:0]  snap_a8_q, snap_a8_d;
    logic [COL_W-1:0] col_q,    col_d;
    logic [POS_W-1:0] px_q,     px_d;
    logic [POS_W-1:0] py_q,     py_d;

    logic [A8_W-1:0]  in_a8;
    logic [A8_W-1:0]  a8_left;
    logic [A8_W-1:0]  a8_next;
    logic             handshake;
    logic             last_col;

    assign handshake = (state_q == ST_EMIT) && ray_ready;
    assign last_col  = (col_q == LAST_COL);

    // Input angle (degrees + thousandths) folded into eighths.
    assign in_a8 = 12'({angle_X, 3'b000})
                 + {9'd0, frac_to_eighths(angle_Y)};

    // Leftmost ray: snapshot angle plus half the field of view.
    angle_mod_addsub u_add_half_fov (
        .a   (snap_a8_q),
        .b   (HALF_FOV),
        .sub (1'b0),
        .y   (a8_left)
    );

    // Next column to the right: one step clockwise.
    angle_mod_addsub u_sub_step (
        .a   (a8_q),
        .b   (STEP),
        .sub (1'b1),
        .y   (a8_next)
    );

    // Sweep sequencing; frame_start outside IDLE is dropped.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (frame_start) state_d = ST_LOAD;
            ST_LOAD: state_d = ST_EMIT;
            ST_EMIT: if (handshake && last_col) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath next values: snapshot, initial ray, per-column step.
    always_comb begin
        a8_d      = a8_q;
        snap_a8_d = snap_a8_q;
        col_d     = col_q;
        px_d      = px_q;
        py_d      = py_q;
        unique case (state_q)
            ST_IDLE: begin
                if (frame_start) begin
                    snap_a8_d = in_a8;
                    px_d      = playerX;
                    py_d      = playerY;
                end
            end
            ST_LOAD: begin
                a8_d  = a8_left;
                col_d = '0;
            end
            ST_EMIT: begin
                if (handshake && !last_col) begin
                    a8_d  = a8_next;
                    col_d = col_q + 8'd1;
                end
            end
            default: ;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Datapath registers: ray angle, column and pose snapshot.
    always_ff @(posedge clock) begin
        if (reset) begin
            a8_q      <= RESET_A8;
            snap_a8_q <= RESET_A8;
            col_q     <= '0;
            px_q      <= RESET_POS;
            py_q      <= RESET_POS;
        end else begin
            a8_q      <= a8_d;
            snap_a8_q <= snap_a8_d;
            col_q     <= col_d;
            px_q      <= px_d;
            py_q      <= py_d;
        end
    end

    assign ray_valid   = (state_q == ST_EMIT);
    assign busy        = (state_q != ST_IDLE);
    assign frame_done  = (state_q == ST_DONE);
    assign ray_column  = col_q;
    assign ray_angle_X = {1'b0, a8_q[A8_W-1:3]};
    assign ray_angle_Y = eighths_to_frac(a8_q[2:0]);
    assign ray_playerX = px_q;
    assign ray_playerY = py_q;

endmodule

// File: tb/tb_ray_angle_generator.sv
// Scoreboard bench for ray_angle_generator: stimulus pushes expected
// rays, a negedge monitor pops and compares on every handshake.
module tb_ray_angle_generator;

    localparam int NCOL = 160;

    logic        clock = 1'b0;
    logic        reset;
    logic        frame_start;
    logic [12:0] playerX, playerY;
    logic [9:0]  angle_X, angle_Y;
    logic        ray_ready;
    logic        ray_valid;
    logic [7:0]  ray_column;
    logic [9:0]  ray_angle_X, ray_angle_Y;
    logic [12:0] ray_playerX, ray_playerY;
    logic        busy;
    logic        frame_done;

    always #5 clock = ~clock;

    ray_angle_generator dut (
        .clock       (clock),
        .reset       (reset),
        .frame_start (frame_start),
        .playerX     (playerX),
        .playerY     (playerY),
        .angle_X     (angle_X),
        .angle_Y     (angle_Y),
        .ray_ready   (ray_ready),
        .ray_valid   (ray_valid),
        .ray_column  (ray_column),
        .ray_angle_X (ray_angle_X),
        .ray_angle_Y (ray_angle_Y),
        .ray_playerX (ray_playerX),
        .ray_playerY (ray_playerY),
        .busy        (busy),
        .frame_done  (frame_done)
    );

    typedef struct {
        int fid;
        int col;
        int ax;
        int ay;
        int px;
        int py;
    } exp_t;

    exp_t sb[$];
    exp_t em;
    int   n_chk = 0;
    int   n_pass = 0;
    int   done_cnt = 0;
    bit   exp_done = 1'b0;

    // Hand-computed spot values: frame id, column, degrees, thousandths.
    localparam int NSP = 11;
    int sp_f[NSP] = '{1, 1, 1, 2, 2, 2, 3, 3, 3, 4, 6};
    int sp_c[NSP] = '{0, 1, 159, 106, 107, 159, 0, 80, 159, 3, 0};
    int sp_x[NSP] = '{120, 119, 60, 0, 359, 340, 20, 350, 320, 74, 230};
    int sp_y[NSP] = '{0, 625, 375, 250, 875, 375, 0, 0, 375, 0, 500};

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // Input contract on the angle presented with frame_start.
    always @(posedge clock) begin
        if (frame_start && !reset) begin
            assert (angle_X <= 10'd359 && angle_Y <= 10'd875
                    && (angle_Y % 10'd125) == 10'd0)
            else $error("angle input outside contract");
        end
    end

    // Monitor: frame_done pulse check and ray scoreboard.
    always @(negedge clock) begin
        if (!reset) begin
            if (exp_done) begin
                chk("frame_done_pulse", int'(frame_done), 1);
                exp_done = 1'b0;
            end else if (frame_done) begin
                chk("frame_done_unexpected", 1, 0);
            end
            if (frame_done) done_cnt++;
            if (ray_valid && ray_ready) begin
                if (sb.size() == 0) begin
                    chk("ray_unexpected", 1, 0);
                end else begin
                    em = sb.pop_front();
                    chk("ray_column", int'(ray_column), em.col);
                    chk("ray_angle_X", int'(ray_angle_X), em.ax);
                    chk("ray_angle_Y", int'(ray_angle_Y), em.ay);
                    chk("ray_playerX", int'($signed(ray_playerX)), em.px);
                    chk("ray_playerY", int'($signed(ray_playerY)), em.py);
                    chk("busy_in_emit", int'(busy), 1);
                    for (int i = 0; i < NSP; i++) begin
                        if (sp_f[i] == em.fid && sp_c[i] == em.col) begin
                            chk("spot_X", int'(ray_angle_X), sp_x[i]);
                            chk("spot_Y", int'(ray_angle_Y), sp_y[i]);
                        end
                    end
                    if (em.col == NCOL - 1) exp_done = 1'b1;
                end
            end
        end
    end

    // Issue frame_start (caller sits at posedge+1) and push expectations.
    task automatic start_frame(input int fid, input int ax, input int ay,
                               input int px, input int py);
        int a0;
        int v;
        exp_t e;
        angle_X = 10'(ax);
        angle_Y = 10'(ay);
        playerX = 13'(px);
        playerY = 13'(py);
        frame_start = 1'b1;
        a0 = ax * 8 + ay / 125;
        for (int c = 0; c < NCOL; c++) begin
            v = (a0 + 240 - 3 * c) % 2880;
            if (v < 0) v += 2880;
            e.fid = fid;
            e.col = c;
            e.ax  = v / 8;
            e.ay  = (v % 8) * 125;
            e.px  = px;
            e.py  = py;
            sb.push_back(e);
        end
        @(posedge clock); #1;
        frame_start = 1'b0;
    endtask

    task automatic wait_frame();
        int start;
        int k;
        start = done_cnt;
        k = 0;
        while (k < 1000 && done_cnt == start) begin
            @(posedge clock); #1;
            k++;
        end
        chk("frame_done_seen", int'(done_cnt != start), 1);
        chk("sb_drained", sb.size(), 0);
    endtask

    task automatic wait_col(input int c);
        int k;
        k = 0;
        while (k < 500 && !(ray_valid && int'(ray_column) == c)) begin
            @(posedge clock); #1;
            k++;
        end
        chk("reach_column", int'(ray_column), c);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_valid", int'(ray_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(frame_done), 0);
        chk("rst_column", int'(ray_column), 0);
        chk("rst_angle_X", int'(ray_angle_X), 90);
        chk("rst_angle_Y", int'(ray_angle_Y), 0);
        chk("rst_playerX", int'(ray_playerX), 96);
        chk("rst_playerY", int'(ray_playerY), 96);
    endtask

    initial begin
        reset = 1'b1;
        frame_start = 1'b0;
        ray_ready = 1'b1;
        playerX = '0;
        playerY = '0;
        angle_X = '0;
        angle_Y = '0;
        repeat (3) @(posedge clock);
        #1;
        chk_reset_outputs();
        reset = 1'b0;
        @(posedge clock); #1;

        // Frame 1: 90.000, nominal sweep
        start_frame(1, 90, 0, 100, -200);
        wait_frame();

        // Frame 2: lower wrap through 0
        start_frame(2, 10, 0, -4096, 4095);
        wait_frame();

        // Frame 3: upper wrap through 360
        start_frame(3, 350, 0, 7, 8);
        wait_frame();

        // Frame 4: backpressure on column 3
        start_frame(4, 45, 125, -1234, 55);
        wait_col(3);
        ray_ready = 1'b0;
        repeat (5) begin
            @(posedge clock); #1;
            chk("bp_valid", int'(ray_valid), 1);
            chk("bp_column", int'(ray_column), 3);
            chk("bp_angle_X", int'(ray_angle_X), 74);
            chk("bp_angle_Y", int'(ray_angle_Y), 0);
        end
        ray_ready = 1'b1;
        @(posedge clock); #1;
        chk("bp_next_column", int'(ray_column), 4);
        chk("bp_next_X", int'(ray_angle_X), 73);
        chk("bp_next_Y", int'(ray_angle_Y), 625);
        wait_frame();

        // Frame 5: inputs change and a stray frame_start mid-sweep
        start_frame(5, 0, 0, 11, 22);
        wait_col(40);
        angle_X = 10'd200;
        angle_Y = 10'd500;
        playerX = 13'd999;
        playerY = 13'd888;
        frame_start = 1'b1;
        @(posedge clock); #1;
        frame_start = 1'b0;
        wait_frame();

        // Frame 6: picks up 200.500 from the new start
        start_frame(6, 200, 500, 999, 888);
        wait_frame();

        // Frame 7: reset while column 50 is valid
        start_frame(7, 123, 875, 300, 301);
        wait_col(50);
        reset = 1'b1;
        ray_ready = 1'b0;
        @(posedge clock); #1;
        chk_reset_outputs();
        sb.delete();
        reset = 1'b0;
        ray_ready = 1'b1;
        repeat (4) begin
            @(posedge clock); #1;
            chk("post_rst_idle", int'(busy), 0);
        end

        // Frame 8: full sweep after the abort
        start_frame(8, 270, 750, -1, -2);
        wait_frame();

        repeat (3) @(posedge clock);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
